regfile_synth_clr: RTL and testbench
====================================

Name: regfile_synth_clr

Overview:
Parametrised synthesized multi-port register file, the next generation of the core's flop-based regfile.
- Adds a hardware clear sequencer that zeroes every entry after reset, gated by a ready_o flag.
- Adds registered, held read data with optional same-cycle write-to-read bypass.
- Adds deterministic resolution of multi-port write conflicts.
- Sits in the vanilla core's integer/FP register-file slot and in accelerator scratch register banks.

Parameters:
- width_p, 32, data width in bits.
- els_p, 32, number of entries; addr_width_lp = `BSG_SAFE_CLOG2(els_p).
- num_rs_p, 2, number of read ports.
- num_ws_p, 1, number of write ports.
- x0_tied_to_zero_p, 1, entry 0 not stored; always reads 0; writes to it are dropped.
- bypass_p, 1, 1 = same-cycle write data is forwarded to a read of the same address.
- clear_on_reset_p, 1, 1 = sequencer zeroes all stored entries after reset.

Ports:
- clk_i, in, 1, clock.
- reset_i, in, 1, reset. Synchronous, active-high.
- ready_o, out, 1, regfile initialised; reads and writes accepted.
- w_v_i, in, num_ws_p, per-port write valid.
- w_addr_i, in, num_ws_p x addr_width_lp, write addresses.
- w_data_i, in, num_ws_p x width_p, write data.
- r_v_i, in, num_rs_p, per-port read valid.
- r_addr_i, in, num_rs_p x addr_width_lp, read addresses.
- r_data_o, out, num_rs_p x width_p, registered read data.
- parity_err_o, out, num_rs_p, per-port parity error flag (see Optional Feature).

Behaviour:
- Reset values: r_data_o = 0, ready_o = 0, parity_err_o = 0. Sequencer state = CLEAR if clear_on_reset_p, else DONE.
- FSM states: CLEAR, DONE.
  - CLEAR: counter starts at 1 if x0_tied_to_zero_p, else 0.
  - CLEAR: writes zero to the entry at counter each cycle; increments counter.
  - CLEAR: after writing entry els_p-1, moves to DONE next cycle.
  - DONE: ready_o = 1, registered.
  - Clear cost: els_p-1 cycles (x0 tied) or els_p cycles (not tied); ready_o rises the following cycle.
- clear_on_reset_p = 0: ready_o = 1 the first cycle after reset_i deasserts; contents undefined.
- While ready_o = 0: w_v_i and r_v_i are ignored; r_data_o holds its value (0 after reset).
- reset_i asserted mid-CLEAR restarts the counter at its start value; ready_o drops to 0 the next cycle.
- Read: r_v_i[i] on edge N loads r_data_o[i] with entry r_addr_i[i] by edge N (1-cycle latency).
  - r_data_o[i] holds until the next accepted read on port i.
  - Later writes to that address do NOT change the held r_data_o.
- x0 tied: a read of address 0 returns 0; a write to address 0 has no effect (not an error).
- Bypass (bypass_p = 1): a read and a write to the same address in the same cycle return the new write data.
- bypass_p = 0: same-cycle read returns the old contents (read-before-write).
- Multiple writes to one address in one cycle: the highest-index write port wins, for both storage and bypass.
- Addresses >= els_p (non-power-of-two els_p): writes dropped, reads return 0.
- reset_i does not clear storage; only the sequencer does.

Optional Feature:
- Macro: REGFILE_SYNTH_PARITY_EN.
- Defined:
  - Each stored entry carries one even-parity bit, computed at write time; the clear sequencer writes parity 0.
  - On an accepted read, parity_err_o[i] asserts in the same cycle r_data_o[i] updates if the stored parity mismatches.
  - parity_err_o[i] holds with the data and is cleared by the next accepted read.
  - Bypassed reads and x0 reads never flag.
- Not defined: no parity storage; parity_err_o tied to 0.

Test Plan:
- Reset with els_p=32, x0 tied → ready_o = 0 for 31 cycles then 1; reads of addresses 1..31 return 0.
- After ready: write addr 5 = 0xDEADBEEF; read addr 5 next cycle → r_data_o[0] = 0xDEADBEEF one cycle later; subsequent write addr 5 = 0x1 leaves r_data_o[0] at 0xDEADBEEF until the next read.
- Same-cycle write addr 7 = 0x1234 and read addr 7 → 0x1234 with bypass_p=1, prior value 0x0 with bypass_p=0.
- num_ws_p=2, both ports write addr 3 (0xAAAA on port 0, 0x5555 on port 1) → read returns 0x5555; write addr 0 = 0xFFFF → read addr 0 returns 0.
- reset_i pulsed at clear cycle 10 → counter restarts; ready_o rises 31 cycles after the second reset deasserts; writes issued during CLEAR are not visible afterwards.
- With REGFILE_SYNTH_PARITY_EN: write addr 9 = 0x3, force-flip one stored data bit, read addr 9 → parity_err_o[0] = 1; next read of clean addr 4 → 0.

Source files
------------

// File: rtl/regfile_synth_clr.sv
// Flop-based multi-port register file with a post-reset clear sequencer, held read data and optional bypass.
// Optional per-entry even parity is enabled by defining REGFILE_SYNTH_PARITY_EN.
module regfile_synth_clr #(
   parameter int width_p           = 32,
   parameter int els_p             = 32,
   parameter int num_rs_p          = 2,
   parameter int num_ws_p          = 1,
   parameter int x0_tied_to_zero_p = 1,
   parameter int bypass_p          = 1,
   parameter int clear_on_reset_p  = 1,
   localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   output logic                              ready_o,
   input  logic [num_ws_p-1:0]               w_v_i,
   input  logic [num_ws_p*addr_width_lp-1:0] w_addr_i,
   input  logic [num_ws_p*width_p-1:0]       w_data_i,
   input  logic [num_rs_p-1:0]               r_v_i,
   input  logic [num_rs_p*addr_width_lp-1:0] r_addr_i,
   output logic [num_rs_p*width_p-1:0]       r_data_o,
   output logic [num_rs_p-1:0]               parity_err_o
);

   localparam logic [addr_width_lp-1:0] cnt_start_lp =
      (x0_tied_to_zero_p != 0) ? addr_width_lp'(1) : '0;
   localparam logic [addr_width_lp-1:0] cnt_last_lp = addr_width_lp'(els_p - 1);

   typedef enum logic {CLEAR, DONE} state_e;

   state_e                   state_r, state_n;
   logic [addr_width_lp-1:0] cnt_r, cnt_n;
   logic                     ready_r;

   logic [width_p-1:0]       mem [els_p];
`ifdef REGFILE_SYNTH_PARITY_EN
   logic                     mem_par [els_p];
   logic [num_rs_p-1:0]      perr_r;
   logic                     perr_n [num_rs_p];
`endif

   logic [addr_width_lp-1:0] w_addr [num_ws_p];
   logic [width_p-1:0]       w_data [num_ws_p];
   logic [num_ws_p-1:0]      w_en;
   logic [addr_width_lp-1:0] r_addr [num_rs_p];
   logic [width_p-1:0]       rd_n   [num_rs_p];
   logic [num_rs_p*width_p-1:0] r_data_r;

   function automatic logic in_range(input logic [addr_width_lp-1:0] a);
      return (32'(a) < els_p);
   endfunction

   function automatic logic is_zero_reg(input logic [addr_width_lp-1:0] a);
      return (x0_tied_to_zero_p != 0) && (a == '0);
   endfunction

   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      case (state_r)
         CLEAR: begin
            if (cnt_r == cnt_last_lp) begin
               state_n = DONE;
            end else begin
               cnt_n = cnt_r + addr_width_lp'(1);
            end
         end
         DONE:    state_n = DONE;
         default: state_n = DONE;
      endcase
   end

   // ready_o follows the next state so it rises on the edge that writes the last entry
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= (clear_on_reset_p != 0) ? CLEAR : DONE;
         cnt_r   <= cnt_start_lp;
         ready_r <= 1'b0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         ready_r <= (state_n == DONE);
      end
   end

   always_comb begin
      for (int j = 0; j < num_ws_p; j++) begin
         w_addr[j] = w_addr_i[j*addr_width_lp +: addr_width_lp];
         w_data[j] = w_data_i[j*width_p +: width_p];
         w_en[j]   = ready_r && w_v_i[j] && in_range(w_addr[j]) && !is_zero_reg(w_addr[j]);
      end
      for (int i = 0; i < num_rs_p; i++) begin
         r_addr[i] = r_addr_i[i*addr_width_lp +: addr_width_lp];
      end
   end

   // Later ports are applied last, so the highest-index writer wins on a conflict
   always_ff @(posedge clk_i) begin
      if (!reset_i && state_r == CLEAR) begin
         mem[cnt_r] <= '0;
`ifdef REGFILE_SYNTH_PARITY_EN
         mem_par[cnt_r] <= 1'b0;
`endif
      end
      for (int j = 0; j < num_ws_p; j++) begin
         if (w_en[j]) begin
            mem[w_addr[j]] <= w_data[j];
`ifdef REGFILE_SYNTH_PARITY_EN
            mem_par[w_addr[j]] <= ^w_data[j];
`endif
         end
      end
   end

   always_comb begin
      for (int i = 0; i < num_rs_p; i++) begin
         rd_n[i] = '0;
`ifdef REGFILE_SYNTH_PARITY_EN
         perr_n[i] = 1'b0;
`endif
         if (in_range(r_addr[i]) && !is_zero_reg(r_addr[i])) begin
            rd_n[i] = mem[r_addr[i]];
`ifdef REGFILE_SYNTH_PARITY_EN
            perr_n[i] = (^mem[r_addr[i]]) != mem_par[r_addr[i]];
`endif
            if (bypass_p != 0) begin
               for (int j = 0; j < num_ws_p; j++) begin
                  if (w_en[j] && (w_addr[j] == r_addr[i])) begin
                     rd_n[i] = w_data[j];
`ifdef REGFILE_SYNTH_PARITY_EN
                     perr_n[i] = 1'b0;
`endif
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_data_r <= '0;
`ifdef REGFILE_SYNTH_PARITY_EN
         perr_r   <= '0;
`endif
      end else if (ready_r) begin
         for (int i = 0; i < num_rs_p; i++) begin
            if (r_v_i[i]) begin
               r_data_r[i*width_p +: width_p] <= rd_n[i];
`ifdef REGFILE_SYNTH_PARITY_EN
               perr_r[i] <= perr_n[i];
`endif
            end
         end
      end
   end

   assign ready_o  = ready_r;
   assign r_data_o = r_data_r;
`ifdef REGFILE_SYNTH_PARITY_EN
   assign parity_err_o = perr_r;
`else
   assign parity_err_o = '0;
`endif

endmodule

// File: tb/tb_regfile_synth_clr.sv
// Bench for regfile_synth_clr: DUT A (32x32, x0 tied, 2 write ports, bypass) and
// DUT B (20x16, x0 stored, 1 write port, no bypass) checked against array models.
module tb_regfile_synth_clr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        a_reset, a_ready;
   logic [1:0]  a_w_v, a_r_v, a_perr;
   logic [9:0]  a_w_addr, a_r_addr;
   logic [63:0] a_w_data, a_r_data;

   logic        b_reset, b_ready;
   logic [0:0]  b_w_v;
   logic [4:0]  b_w_addr;
   logic [15:0] b_w_data;
   logic [1:0]  b_r_v, b_perr;
   logic [9:0]  b_r_addr;
   logic [31:0] b_r_data;

   logic [31:0] ma [32];
   logic [31:0] a_exp [2];
   logic [15:0] mb [20];
   logic [15:0] b_exp [2];

   regfile_synth_clr #(
      .width_p(32), .els_p(32), .num_rs_p(2), .num_ws_p(2),
      .x0_tied_to_zero_p(1), .bypass_p(1), .clear_on_reset_p(1)
   ) dut_a (
      .clk_i(clk), .reset_i(a_reset), .ready_o(a_ready),
      .w_v_i(a_w_v), .w_addr_i(a_w_addr), .w_data_i(a_w_data),
      .r_v_i(a_r_v), .r_addr_i(a_r_addr), .r_data_o(a_r_data),
      .parity_err_o(a_perr)
   );

   regfile_synth_clr #(
      .width_p(16), .els_p(20), .num_rs_p(2), .num_ws_p(1),
      .x0_tied_to_zero_p(0), .bypass_p(0), .clear_on_reset_p(1)
   ) dut_b (
      .clk_i(clk), .reset_i(b_reset), .ready_o(b_ready),
      .w_v_i(b_w_v), .w_addr_i(b_w_addr), .w_data_i(b_w_data),
      .r_v_i(b_r_v), .r_addr_i(b_r_addr), .r_data_o(b_r_data),
      .parity_err_o(b_perr)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      a_w_v = '0; a_w_addr = '0; a_w_data = '0; a_r_v = '0; a_r_addr = '0;
      b_w_v = '0; b_w_addr = '0; b_w_data = '0; b_r_v = '0; b_r_addr = '0;
   endtask

   // One DUT A cycle: model computes what each accepted read must return, then commits writes
   task automatic a_cycle(input logic [1:0] wv, input logic [4:0] wa0, input logic [31:0] wd0,
                          input logic [4:0] wa1, input logic [31:0] wd1,
                          input logic [1:0] rv, input logic [4:0] ra0, input logic [4:0] ra1,
                          input string tag);
      logic [4:0]  wa [2];
      logic [31:0] wd [2];
      logic [4:0]  ra [2];
      wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
      a_w_v = wv; a_w_addr = {wa1, wa0}; a_w_data = {wd1, wd0};
      a_r_v = rv; a_r_addr = {ra1, ra0};
      for (int p = 0; p < 2; p++) begin
         if (rv[p]) begin
            if (ra[p] == 5'd0) begin
               a_exp[p] = '0;
            end else begin
               a_exp[p] = ma[ra[p]];
               for (int w = 0; w < 2; w++)
                  if (wv[w] && wa[w] == ra[p]) a_exp[p] = wd[w];
            end
         end
      end
      for (int w = 0; w < 2; w++)
         if (wv[w] && wa[w] != 5'd0) ma[wa[w]] = wd[w];
      tick();
      idle_inputs();
      for (int p = 0; p < 2; p++) begin
         checks++;
         if (a_r_data[p*32 +: 32] !== a_exp[p]) begin
            errors++;
            $display("[TB] FAIL %s a_r_data[%0d] got %h want %h", tag, p, a_r_data[p*32 +: 32], a_exp[p]);
         end
      end
      checks++;
      if (a_perr !== 2'b00) begin
         errors++;
         $display("[TB] FAIL %s a_parity_err got %b want 00", tag, a_perr);
      end
   endtask

   // One DUT B cycle: read-before-write, out-of-range addresses read 0 and drop writes
   task automatic b_cycle(input logic wv, input logic [4:0] wa, input logic [15:0] wd,
                          input logic [1:0] rv, input logic [4:0] ra0, input logic [4:0] ra1,
                          input string tag);
      logic [4:0] ra [2];
      ra[0] = ra0; ra[1] = ra1;
      b_w_v = wv; b_w_addr = wa; b_w_data = wd; b_r_v = rv; b_r_addr = {ra1, ra0};
      for (int p = 0; p < 2; p++)
         if (rv[p]) b_exp[p] = (ra[p] < 5'd20) ? mb[ra[p]] : 16'h0;
      if (wv && wa < 5'd20) mb[wa] = wd;
      tick();
      idle_inputs();
      for (int p = 0; p < 2; p++) begin
         checks++;
         if (b_r_data[p*16 +: 16] !== b_exp[p]) begin
            errors++;
            $display("[TB] FAIL %s b_r_data[%0d] got %h want %h", tag, p, b_r_data[p*16 +: 16], b_exp[p]);
         end
      end
   endtask

   task automatic test_reset;
      int na, nb;
      a_reset = 1'b1; b_reset = 1'b1;
      idle_inputs();
      repeat (3) tick();
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ready got a=%b b=%b want 0 0", a_ready, b_ready);
      end
      checks++;
      if (a_r_data !== 64'h0 || b_r_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_rdata got a=%h b=%h want 0", a_r_data, b_r_data);
      end
      checks++;
      if (a_perr !== 2'b00 || b_perr !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_parity got a=%b b=%b want 00", a_perr, b_perr);
      end
      a_reset = 1'b0; b_reset = 1'b0;
      na = -1; nb = -1;
      for (int n = 1; n <= 100 && (na < 0 || nb < 0); n++) begin
         tick();
         if (a_ready === 1'b1 && na < 0) na = n;
         if (b_ready === 1'b1 && nb < 0) nb = n;
      end
      checks++;
      if (na != 31) begin
         errors++;
         $display("[TB] FAIL clear_cycles_a got %0d want 31", na);
      end
      checks++;
      if (nb != 20) begin
         errors++;
         $display("[TB] FAIL clear_cycles_b got %0d want 20", nb);
      end
      foreach (ma[k]) ma[k] = '0;
      foreach (mb[k]) mb[k] = '0;
      a_exp[0] = '0; a_exp[1] = '0; b_exp[0] = '0; b_exp[1] = '0;
      for (int k = 1; k < 32; k += 2)
         a_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'(k), 5'(k + 1), "cleared_a");
      for (int k = 0; k < 20; k += 2)
         b_cycle(1'b0, 5'd0, 16'h0, 2'b11, 5'(k), 5'(k + 1), "cleared_b");
   endtask

   task automatic test_read_hold;
      a_cycle(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, "hold_write");
      a_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, "hold_read");
      checks++;
      if (a_r_data[31:0] !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL hold_value got %h want deadbeef", a_r_data[31:0]);
      end
      a_cycle(2'b01, 5'd5, 32'h1, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, "hold_after_write");
      a_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, "hold_idle");
      a_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd5, "hold_reread");
   endtask

   task automatic test_bypass;
      a_cycle(2'b01, 5'd7, 32'h1234, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, "bypass_a");
      checks++;
      if (a_r_data[31:0] !== 32'h1234) begin
         errors++;
         $display("[TB] FAIL bypass_value got %h want 00001234", a_r_data[31:0]);
      end
   endtask

   task automatic test_write_conflict;
      a_cycle(2'b11, 5'd3, 32'hAAAA, 5'd3, 32'h5555, 2'b01, 5'd3, 5'd0, "conflict_bypass");
      a_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd3, "conflict_stored");
      checks++;
      if (a_r_data !== {32'h5555, 32'h5555}) begin
         errors++;
         $display("[TB] FAIL conflict_value got %h want 0000555500005555", a_r_data);
      end
      a_cycle(2'b11, 5'd0, 32'hFFFF, 5'd0, 32'hFFFF, 2'b01, 5'd0, 5'd0, "x0_same_cycle");
      a_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, "x0_read");
   endtask

   task automatic test_b_rules;
      b_cycle(1'b1, 5'd7, 16'h1234, 2'b01, 5'd7, 5'd0, "rbw_old");
      b_cycle(1'b0, 5'd0, 16'h0, 2'b01, 5'd7, 5'd0, "rbw_new");
      checks++;
      if (b_r_data[15:0] !== 16'h1234) begin
         errors++;
         $display("[TB] FAIL rbw_value got %h want 1234", b_r_data[15:0]);
      end
      b_cycle(1'b1, 5'd0, 16'h00FF, 2'b00, 5'd0, 5'd0, "b_addr0_write");
      b_cycle(1'b0, 5'd0, 16'h0, 2'b10, 5'd0, 5'd0, "b_addr0_read");
      b_cycle(1'b1, 5'd19, 16'hCAFE, 2'b00, 5'd0, 5'd0, "b_top_write");
      b_cycle(1'b1, 5'd25, 16'hBEEF, 2'b00, 5'd0, 5'd0, "b_oor_write");
      b_cycle(1'b0, 5'd0, 16'h0, 2'b11, 5'd19, 5'd25, "b_oor_read");
   endtask

   task automatic test_random;
      for (int n = 0; n < 300; n++)
         a_cycle(2'($urandom), 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
                 2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), "random_a");
      for (int n = 0; n < 200; n++)
         b_cycle(1'($urandom), 5'($urandom_range(0, 23)), 16'($urandom),
                 2'($urandom), 5'($urandom_range(0, 23)), 5'($urandom_range(0, 23)), "random_b");
   endtask

   task automatic test_mid_clear_reset;
      int na;
      a_reset = 1'b1;
      repeat (2) tick();
      a_reset = 1'b0;
      for (int n = 0; n < 10; n++) begin
         a_w_v = 2'b11; a_w_addr = {5'd3, 5'd2}; a_w_data = {32'hFFFF0003, 32'hFFFF0002};
         a_r_v = 2'b11; a_r_addr = {5'd5, 5'd2};
         tick();
         checks++;
         if (a_ready !== 1'b0 || a_r_data !== 64'h0) begin
            errors++;
            $display("[TB] FAIL clear_ignores_ops got ready=%b data=%h want 0 0", a_ready, a_r_data);
         end
      end
      idle_inputs();
      a_reset = 1'b1;
      tick();
      checks++;
      if (a_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset_ready got %b want 0", a_ready);
      end
      a_reset = 1'b0;
      na = -1;
      for (int n = 1; n <= 100 && na < 0; n++) begin
         tick();
         if (a_ready === 1'b1) na = n;
      end
      checks++;
      if (na != 31) begin
         errors++;
         $display("[TB] FAIL restart_cycles got %0d want 31", na);
      end
      foreach (ma[k]) ma[k] = '0;
      a_exp[0] = '0; a_exp[1] = '0;
      a_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd2, 5'd3, "clear_writes_dropped");
      a_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd7, "clear_rezeroed");
   endtask

`ifdef REGFILE_SYNTH_PARITY_EN
   task automatic test_parity;
      a_cycle(2'b11, 5'd9, 32'h3, 5'd4, 32'h7, 2'b00, 5'd0, 5'd0, "parity_write");
      dut_a.mem[9] = dut_a.mem[9] ^ 32'h1;
      ma[9] = 32'h2;
      a_r_v = 2'b01; a_r_addr = {5'd0, 5'd9};
      tick();
      idle_inputs();
      a_exp[0] = 32'h2;
      checks++;
      if (a_perr[0] !== 1'b1 || a_r_data[31:0] !== 32'h2) begin
         errors++;
         $display("[TB] FAIL parity_flag got err=%b data=%h want 1 00000002", a_perr[0], a_r_data[31:0]);
      end
      a_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd4, 5'd0, "parity_clean");
   endtask
`endif

   initial begin
      a_reset = 1'b1;
      b_reset = 1'b1;
      idle_inputs();
      test_reset();
      test_read_hold();
      test_bypass();
      test_write_conflict();
      test_b_rules();
      test_random();
      test_mid_clear_reset();
`ifdef REGFILE_SYNTH_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
